// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush/valid controller.
// The datapath side drives hazard and redirect information; the controller drives strobes.
interface pipeline_ctrl_if #(
  parameter int unsigned NStages = 4,
  parameter int unsigned CntW    = 32,
  parameter int unsigned RegW    = 5
);
  logic               enable;
  logic [RegW-1:0]    id_rs;
  logic [RegW-1:0]    id_rt;
  logic               id_uses_rt;
  logic               ex_mem_read;
  logic [RegW-1:0]    ex_waddr;
  logic               redirect;

  logic               pc_en;
  logic [NStages-1:0] stage_en;
  logic [NStages-1:0] stage_flush;
  logic [NStages-1:0] stage_valid;
  logic               stall;
  logic [CntW-1:0]    cycle_cnt;
  logic [CntW-1:0]    stall_cnt;
  logic [CntW-1:0]    flush_cnt;

  modport master (
    output enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_waddr, redirect,
    input  pc_en, stage_en, stage_flush, stage_valid, stall, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_waddr, redirect,
    output pc_en, stage_en, stage_flush, stage_valid, stall, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush/valid controller for an in-order pipeline: load-use bubbles, branch squash,
// per-register valid tracking and saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned NStages     = 4,
  parameter int unsigned BrStage     = 2,
  parameter int unsigned StallCycles = 1,
  parameter int unsigned CntW        = 32,
  parameter int unsigned RegW        = 5
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e             state_q, state_d;
  logic [1:0]         left_q, left_d;
  logic [NStages-1:0] valid_q, valid_d;
  logic [CntW-1:0]    cycle_q, cycle_d;
  logic [CntW-1:0]    stallc_q, stallc_d;
  logic [CntW-1:0]    flushc_q, flushc_d;

  logic               haz, hred;
  logic               pc_en, stall;
  logic [NStages-1:0] en, flush, src_valid;

  // $0 is never a real producer, so a load targeting it cannot create a hazard.
  assign haz = valid_q[0] & valid_q[1] & bus.ex_mem_read & (bus.ex_waddr != '0) &
               ((bus.ex_waddr == bus.id_rs) |
                (bus.id_uses_rt & (bus.ex_waddr == bus.id_rt)));

  assign hred      = bus.redirect & valid_q[BrStage];
  assign src_valid = {valid_q[NStages-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    pc_en   = 1'b0;
    en      = '0;
    flush   = '0;
    stall   = 1'b0;
    if (bus.enable) begin
      if (hred) begin
        pc_en   = 1'b1;
        en      = '1;
        for (int unsigned i = 0; i < NStages; i++) begin
          flush[i] = (i <= BrStage);
        end
        state_d = StRun;
        left_d  = 2'd0;
      end else if (haz || (state_q == StStall)) begin
        // Hold IF/ID and PC, inject a bubble into ID/EX, let older stages drain.
        stall    = 1'b1;
        en       = '1;
        en[0]    = 1'b0;
        en[1]    = 1'b0;
        flush[1] = 1'b1;
        if (state_q == StRun) begin
          if (StallCycles > 1) begin
            state_d = StStall;
            left_d  = 2'(StallCycles - 1);
          end
        end else begin
          left_d = left_q - 2'd1;
          if (left_q == 2'd1) begin
            state_d = StRun;
          end
        end
      end else begin
        pc_en = 1'b1;
        en    = '1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < NStages; i++) begin
      if (flush[i]) begin
        valid_d[i] = 1'b0;
      end else if (en[i]) begin
        valid_d[i] = src_valid[i];
      end
    end
  end

  always_comb begin
    cycle_d  = cycle_q;
    stallc_d = stallc_q;
    flushc_d = flushc_q;
    if (bus.enable && (cycle_q != '1)) begin
      cycle_d = cycle_q + 1'b1;
    end
    if (stall && (stallc_q != '1)) begin
      stallc_d = stallc_q + 1'b1;
    end
    if (bus.enable && hred && (flushc_q != '1)) begin
      flushc_d = flushc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= StRun;
      left_q   <= 2'd0;
      valid_q  <= '0;
      cycle_q  <= '0;
      stallc_q <= '0;
      flushc_q <= '0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      valid_q  <= valid_d;
      cycle_q  <= cycle_d;
      stallc_q <= stallc_d;
      flushc_q <= flushc_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.stage_en    = en;
  assign bus.stage_flush = flush;
  assign bus.stage_valid = valid_q;
  assign bus.stall       = stall;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.stall_cnt   = stallc_q;
  assign bus.flush_cnt   = flushc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances cover stall lengths 1, 2 and 3
// and a narrow counter for saturation.
module tb_pipeline_ctrl;

  logic clk;
  logic arst_n;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  pipeline_ctrl_if #(.NStages(4), .CntW(4),  .RegW(5)) a_if ();
  pipeline_ctrl_if #(.NStages(4), .CntW(32), .RegW(5)) b_if ();
  pipeline_ctrl_if #(.NStages(4), .CntW(32), .RegW(5)) c_if ();

  pipeline_ctrl #(.NStages(4), .BrStage(2), .StallCycles(1), .CntW(4), .RegW(5)) u_a (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (a_if.slave)
  );

  pipeline_ctrl #(.NStages(4), .BrStage(2), .StallCycles(2), .CntW(32), .RegW(5)) u_b (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (b_if.slave)
  );

  pipeline_ctrl #(.NStages(4), .BrStage(2), .StallCycles(3), .CntW(32), .RegW(5)) u_c (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (c_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    a_if.enable = 0; a_if.id_rs = 0; a_if.id_rt = 0; a_if.id_uses_rt = 0;
    a_if.ex_mem_read = 0; a_if.ex_waddr = 0; a_if.redirect = 0;
    b_if.enable = 0; b_if.id_rs = 0; b_if.id_rt = 0; b_if.id_uses_rt = 0;
    b_if.ex_mem_read = 0; b_if.ex_waddr = 0; b_if.redirect = 0;
    c_if.enable = 0; c_if.id_rs = 0; c_if.id_rt = 0; c_if.id_uses_rt = 0;
    c_if.ex_mem_read = 0; c_if.ex_waddr = 0; c_if.redirect = 0;

    #2;
    check("a_rst_valid", a_if.stage_valid, 4'b0000);
    check("a_rst_cycle", a_if.cycle_cnt, 4'd0);
    check("a_dis_pc_en", a_if.pc_en, 1'b0);
    #10;
    arst_n = 1'b1;

    // Fill the pipe on instance A (stall length 1, 4-bit counters)
    a_if.enable = 1;
    #1;
    check("a_norm_pc_en", a_if.pc_en, 1'b1);
    check("a_norm_en", a_if.stage_en, 4'b1111);
    check("a_norm_flush", a_if.stage_flush, 4'b0000);
    tick();
    check("a_fill1", a_if.stage_valid, 4'b0001);
    tick();
    check("a_fill2", a_if.stage_valid, 4'b0011);
    tick();
    check("a_fill3", a_if.stage_valid, 4'b0111);
    tick();
    check("a_fill4", a_if.stage_valid, 4'b1111);
    check("a_cycle4", a_if.cycle_cnt, 4'd4);

    // Load-use on rs: one bubble
    a_if.ex_mem_read = 1; a_if.ex_waddr = 5'd8; a_if.id_rs = 5'd8;
    #1;
    check("a_lu_pc_en", a_if.pc_en, 1'b0);
    check("a_lu_en", a_if.stage_en, 4'b1100);
    check("a_lu_flush", a_if.stage_flush, 4'b0010);
    check("a_lu_stall", a_if.stall, 1'b1);
    tick();
    a_if.ex_mem_read = 0;
    check("a_lu_valid", a_if.stage_valid, 4'b1101);
    check("a_lu_stallcnt", a_if.stall_cnt, 4'd1);
    #1;
    check("a_post_stall", a_if.stall, 1'b0);
    tick();
    tick();
    tick();
    check("a_refill", a_if.stage_valid, 4'b1111);
    check("a_cycle8", a_if.cycle_cnt, 4'd8);

    // Honoured redirect
    a_if.redirect = 1;
    #1;
    check("a_red_flush", a_if.stage_flush, 4'b0111);
    check("a_red_pc_en", a_if.pc_en, 1'b1);
    check("a_red_en", a_if.stage_en, 4'b1111);
    tick();
    check("a_red_valid", a_if.stage_valid, 4'b1000);
    check("a_red_flushcnt", a_if.flush_cnt, 4'd1);

    // Redirect with BR_STAGE register invalid is ignored
    #1;
    check("a_ign_flush", a_if.stage_flush, 4'b0000);
    tick();
    a_if.redirect = 0;
    check("a_ign_flushcnt", a_if.flush_cnt, 4'd1);
    check("a_ign_valid", a_if.stage_valid, 4'b0001);
    tick();
    check("a_pre_r0_valid", a_if.stage_valid, 4'b0011);

    // Load to $0 never stalls
    a_if.ex_mem_read = 1; a_if.ex_waddr = 5'd0; a_if.id_rs = 5'd0;
    #1;
    check("a_r0_stall", a_if.stall, 1'b0);
    check("a_r0_pc_en", a_if.pc_en, 1'b1);
    tick();
    a_if.ex_mem_read = 0;
    check("a_cycle12", a_if.cycle_cnt, 4'd12);

    // Freeze for 5 cycles
    a_if.enable = 0;
    a_if.ex_mem_read = 1; a_if.ex_waddr = 5'd8; a_if.id_rs = 5'd8;
    #1;
    check("a_frz_pc_en", a_if.pc_en, 1'b0);
    check("a_frz_en", a_if.stage_en, 4'b0000);
    check("a_frz_flush", a_if.stage_flush, 4'b0000);
    check("a_frz_stall", a_if.stall, 1'b0);
    repeat (5) tick();
    a_if.ex_mem_read = 0;
    check("a_frz_cycle", a_if.cycle_cnt, 4'd12);
    check("a_frz_valid", a_if.stage_valid, 4'b0111);

    // Saturation: 10 more enabled cycles -> 22 capped at 15
    a_if.enable = 1;
    repeat (10) tick();
    a_if.enable = 0;
    check("a_sat_cycle", a_if.cycle_cnt, 4'd15);
    check("a_sat_stallcnt", a_if.stall_cnt, 4'd1);

    // Instance B: stall length 2, hazard through rt
    b_if.enable = 1;
    repeat (4) tick();
    check("b_fill", b_if.stage_valid, 4'b1111);
    b_if.ex_mem_read = 1; b_if.ex_waddr = 5'd8; b_if.id_rt = 5'd8;
    b_if.id_uses_rt = 1; b_if.id_rs = 5'd3;
    #1;
    check("b_s1_stall", b_if.stall, 1'b1);
    check("b_s1_pc_en", b_if.pc_en, 1'b0);
    tick();
    check("b_s2_stall", b_if.stall, 1'b1);
    check("b_s2_en", b_if.stage_en, 4'b1100);
    check("b_s2_flush", b_if.stage_flush, 4'b0010);
    check("b_s2_valid", b_if.stage_valid, 4'b1101);
    tick();
    b_if.ex_mem_read = 0;
    check("b_s3_valid", b_if.stage_valid, 4'b1001);
    #1;
    check("b_s3_stall", b_if.stall, 1'b0);
    check("b_s3_pc_en", b_if.pc_en, 1'b1);
    check("b_stallcnt", b_if.stall_cnt, 32'd2);

    // Instance C: stall length 3, redirect on second stall cycle
    c_if.enable = 1;
    repeat (4) tick();
    c_if.ex_mem_read = 1; c_if.ex_waddr = 5'd8; c_if.id_rs = 5'd8;
    #1;
    check("c_s1_stall", c_if.stall, 1'b1);
    tick();
    c_if.redirect = 1;
    #1;
    check("c_red_stall", c_if.stall, 1'b0);
    check("c_red_flush", c_if.stage_flush, 4'b0111);
    check("c_red_pc_en", c_if.pc_en, 1'b1);
    tick();
    c_if.redirect = 0; c_if.ex_mem_read = 0;
    check("c_red_valid", c_if.stage_valid, 4'b1000);
    #1;
    check("c_run_stall", c_if.stall, 1'b0);
    check("c_run_pc_en", c_if.pc_en, 1'b1);
    check("c_stallcnt", c_if.stall_cnt, 32'd1);
    check("c_flushcnt", c_if.flush_cnt, 32'd1);

    // Reset in the middle of a stall
    tick();
    tick();
    check("c_pre_rst_valid", c_if.stage_valid, 4'b0011);
    c_if.ex_mem_read = 1;
    #1;
    check("c_pre_rst_stall", c_if.stall, 1'b1);
    tick();
    check("c_in_stall", c_if.stall, 1'b1);
    arst_n = 1'b0;
    #1;
    check("c_rst_valid", c_if.stage_valid, 4'b0000);
    check("c_rst_cycle", c_if.cycle_cnt, 32'd0);
    check("c_rst_stallcnt", c_if.stall_cnt, 32'd0);
    check("c_rst_flushcnt", c_if.flush_cnt, 32'd0);
    check("c_rst_run_stall", c_if.stall, 1'b0);
    check("c_rst_run_pc_en", c_if.pc_en, 1'b1);
    #1;
    arst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
